// File: rtl/pipelined_addsub.sv
`default_nettype none
// ============================================================================
// Module  : pipelined_addsub
// Brief   : Pipelined two's-complement add/sub; carry ripples CHUNK bits per
//           stage with valid/ready back-pressure. WIDTH must be a multiple of
//           CHUNK. Define PIPELINED_ADDSUB_SAT_EN for saturating results.
// Revision: 1.0 - initial release
// ============================================================================
module pipelined_addsub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int STAGES = WIDTH / CHUNK;
  // Sum and skew storage are packed triangularly: stage k keeps (k+1) finished
  // chunks and (STAGES-1-k) unprocessed operand chunks.
  localparam int SUMW = CHUNK * STAGES * (STAGES + 1) / 2;
  localparam int SKW  = (STAGES > 1) ? CHUNK * STAGES * (STAGES - 1) / 2 : 1;

  function automatic int sum_off(input int k);
    return CHUNK * k * (k + 1) / 2;
  endfunction

  function automatic int skw_off(input int k);
    return CHUNK * (k * (STAGES - 1) - k * (k - 1) / 2);
  endfunction

  logic              w_adv;
  logic [WIDTH-1:0]  w_b_eff;
  logic              w_cin_eff;
  logic [STAGES-1:0] valid_q, carry_q, w_v_in, w_c_out;
  logic [SUMW-1:0]   sum_q, sum_d, w_sum_en;
  logic [SKW-1:0]    a_q, a_d, b_q, b_d, w_skw_en;
  logic              ovf_q, ovf_d;

  assign w_adv     = !valid_q[STAGES-1] || out_ready;
  assign in_ready  = w_adv;
  assign w_b_eff   = in_sub ? ~in_b : in_b;
  assign w_cin_eff = in_sub | in_cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int SO = sum_off(k);
    localparam int SN = CHUNK * (k + 1);

    logic [CHUNK-1:0] w_a, w_b, w_s;
    logic             w_c;
    logic [SN-1:0]    w_word;

    if (k == 0) begin : g_first
      assign w_a       = in_a[CHUNK-1:0];
      assign w_b       = w_b_eff[CHUNK-1:0];
      assign w_c       = w_cin_eff;
      assign w_v_in[k] = in_valid;
      assign w_word    = w_s;
      if (STAGES > 1) begin : g_skew
        assign a_d[skw_off(k) +: CHUNK*(STAGES-1)] = in_a[WIDTH-1:CHUNK];
        assign b_d[skw_off(k) +: CHUNK*(STAGES-1)] = w_b_eff[WIDTH-1:CHUNK];
      end
    end else begin : g_rest
      assign w_a       = a_q[skw_off(k-1) +: CHUNK];
      assign w_b       = b_q[skw_off(k-1) +: CHUNK];
      assign w_c       = carry_q[k-1];
      assign w_v_in[k] = valid_q[k-1];
      assign w_word    = {w_s, sum_q[sum_off(k-1) +: CHUNK*k]};
      if (k < STAGES - 1) begin : g_skew
        assign a_d[skw_off(k) +: CHUNK*(STAGES-1-k)] =
          a_q[skw_off(k-1)+CHUNK +: CHUNK*(STAGES-1-k)];
        assign b_d[skw_off(k) +: CHUNK*(STAGES-1-k)] =
          b_q[skw_off(k-1)+CHUNK +: CHUNK*(STAGES-1-k)];
      end
    end

    assign {w_c_out[k], w_s} = {1'b0, w_a} + {1'b0, w_b} + {{CHUNK{1'b0}}, w_c};
    assign w_sum_en[SO +: SN] = {SN{w_v_in[k]}};

    if (k == STAGES - 1) begin : g_last
      logic w_ovf;
      assign w_ovf = (w_a[CHUNK-1] == w_b[CHUNK-1]) && (w_s[CHUNK-1] != w_a[CHUNK-1]);
      assign ovf_d = w_ovf;
`ifdef PIPELINED_ADDSUB_SAT_EN
      // Positive overflow only happens with a non-negative A, so A's sign picks the rail.
      assign sum_d[SO +: SN] = w_ovf ? {w_a[CHUNK-1], {(WIDTH-1){~w_a[CHUNK-1]}}} : w_word;
`else
      assign sum_d[SO +: SN] = w_word;
`endif
    end else begin : g_mid
      assign sum_d[SO +: SN] = w_word;
      assign w_skw_en[skw_off(k) +: CHUNK*(STAGES-1-k)] = {(CHUNK*(STAGES-1-k)){w_v_in[k]}};
    end
  end

  // Data registers load only for valid entries; bubbles move just the valid bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      carry_q <= '0;
      sum_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ovf_q   <= 1'b0;
    end else if (w_adv) begin
      valid_q <= w_v_in;
      carry_q <= (carry_q & ~w_v_in) | (w_c_out & w_v_in);
      sum_q   <= (sum_q & ~w_sum_en) | (sum_d & w_sum_en);
      a_q     <= (a_q & ~w_skw_en) | (a_d & w_skw_en);
      b_q     <= (b_q & ~w_skw_en) | (b_d & w_skw_en);
      if (w_v_in[STAGES-1]) begin
        ovf_q <= ovf_d;
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign out_sum   = sum_q[SUMW-1 -: WIDTH];
  assign out_cout  = carry_q[STAGES-1];
  assign out_ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_addsub.sv
`default_nettype none
// Testbench for pipelined_addsub (WIDTH=8, CHUNK=4): directed vectors, stall
// and reset sequences, and random traffic against an arithmetic model.
module tb_pipelined_addsub;
  localparam int WIDTH = 8;
`ifdef PIPELINED_ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset, in_valid, in_ready, in_cin, in_sub;
  logic             out_valid, out_ready, out_cout, out_ovf;
  logic [WIDTH-1:0] in_a, in_b, out_sum;

  int n_checks = 0;
  int n_errors = 0;

  pipelined_addsub #(.WIDTH(WIDTH), .CHUNK(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .in_sub   (in_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ovf  (out_ovf)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] a, b;
    logic       cin, sub;
    logic [7:0] sum_wrap, sum_sat;
    logic       cout, ovf;
  } vec_t;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } res_t;

  vec_t vecs [10];
  res_t exp_q [$];
  res_t got, want, held;
  int   sent, rcvd;
  logic was_stalled;

  // Reference: true signed value for overflow, unsigned total for carry.
  function automatic res_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic cin, input logic sub);
    int          sa, sb, sres;
    int unsigned ures;
    res_t        r;
    sa = $signed(a);
    sb = $signed(b);
    if (sub) begin
      sres = sa - sb;
      ures = 32'(a) + 32'd256 - 32'(b);
    end else begin
      sres = sa + sb + int'(cin);
      ures = 32'(a) + 32'(b) + 32'(cin);
    end
    r.ovf  = (sres > 127) || (sres < -128);
    r.cout = ures[8];
    r.sum  = ures[7:0];
    if (SAT && r.ovf) r.sum = (sres > 127) ? 8'h7F : 8'h80;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 8'h7F, 1'b0, 1'b1};
    vecs[3] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 8'h80, 1'b1, 1'b1};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 8'h80, 1'b1, 1'b1};
    vecs[6] = '{8'h00, 8'h80, 1'b0, 1'b1, 8'h80, 8'h7F, 1'b0, 1'b1};
    vecs[7] = '{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 8'h47, 1'b0, 1'b0};
    vecs[8] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0};
    vecs[9] = '{8'h33, 8'h33, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0};

    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
    step();
    step();
    check("reset_valid", out_valid, 0);
    check("reset_sum",   out_sum,   0);
    check("reset_cout",  out_cout,  0);
    check("reset_ovf",   out_ovf,   0);
    reset = 1'b0;
    #1 check("reset_in_ready", in_ready, 1);

    // Directed vectors: one result two edges after it is presented.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_a = vecs[i].a; in_b = vecs[i].b; in_cin = vecs[i].cin; in_sub = vecs[i].sub;
      check("vec_in_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      check("vec_not_early", out_valid, 0);
      step();
      check("vec_valid", out_valid, 1);
      check("vec_sum",  out_sum,  SAT ? vecs[i].sum_sat : vecs[i].sum_wrap);
      check("vec_cout", out_cout, vecs[i].cout);
      check("vec_ovf",  out_ovf,  vecs[i].ovf);
    end

    // Back-pressure: two entries fill the pipe, the third waits.
    step(); step(); step();
    out_ready = 1'b0; in_valid = 1'b1; in_sub = 1'b0; in_cin = 1'b0;
    in_a = 8'h01; in_b = 8'h01;
    check("stall_rdy0", in_ready, 1);
    step();
    check("stall_rdy1", in_ready, 1);
    in_a = 8'h02; in_b = 8'h02;
    step();
    in_a = 8'h03; in_b = 8'h03;
    check("stall_rdy_full", in_ready, 0);
    check("stall_first", out_sum, 8'h02);
    step();
    check("stall_hold_valid", out_valid, 1);
    check("stall_hold_sum", out_sum, 8'h02);
    check("stall_rdy_still0", in_ready, 0);
    out_ready = 1'b1;
    #1 check("stall_release_rdy", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("drain1_valid", out_valid, 1);
    check("drain1_sum", out_sum, 8'h04);
    step();
    check("drain2_valid", out_valid, 1);
    check("drain2_sum", out_sum, 8'h06);
    step();
    check("drain_empty", out_valid, 0);

    // Reset with two entries in flight.
    out_ready = 1'b0; in_valid = 1'b1; in_a = 8'h7F; in_b = 8'h7F;
    step();
    in_a = 8'hC0; in_b = 8'hC0;
    step();
    in_valid = 1'b0;
    check("pre_reset_valid", out_valid, 1);
    check("pre_reset_sum", out_sum, SAT ? 8'h7F : 8'hFE);
    check("pre_reset_ovf", out_ovf, 1);
    reset = 1'b1;
    step();
    check("mid_reset_valid", out_valid, 0);
    check("mid_reset_sum",   out_sum,   0);
    check("mid_reset_cout",  out_cout,  0);
    check("mid_reset_ovf",   out_ovf,   0);
    check("mid_reset_rdy",   in_ready,  1);
    reset = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_reset_no_stale", out_valid, 0);
    end

    // Random traffic with random back-pressure.
    sent = 0; rcvd = 0; was_stalled = 1'b0; held = '0;
    for (int cyc = 0; cyc < 5000 && rcvd < 200; cyc++) begin
      out_ready = 1'($urandom);
      in_valid  = (sent < 200) && ($urandom_range(0, 3) != 0);
      in_a = 8'($urandom); in_b = 8'($urandom);
      in_cin = 1'($urandom); in_sub = 1'($urandom);
      #1;
      got = {out_sum, out_cout, out_ovf};
      check("rand_in_ready", in_ready, !out_valid || out_ready);
      if (was_stalled) begin
        check("rand_stall_valid", out_valid, 1);
        check("rand_stall_hold", got, held);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_a, in_b, in_cin, in_sub));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rand_unexpected_result", 1, 0);
        end else begin
          want = exp_q.pop_front();
          check("rand_result", got, want);
          rcvd++;
        end
      end
      was_stalled = out_valid && !out_ready;
      held = got;
      step();
    end
    check("rand_all_received", rcvd, 200);
    check("rand_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined two's-complement adder/subtractor; successor to the 4-bit combinational ripple-carry adder.
- The carry chain is split into CHUNK-bit ripple segments, one register stage per segment, so WIDTH can grow without lengthening the critical path.
- Valid/ready handshake on both sides with full back-pressure.
- Sits between switch/register operand sources and the result display/ALU datapath.

Parameters:
WIDTH, 8, operand and result width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits resolved per pipeline stage.
STAGES, WIDTH/CHUNK (derived localparam), pipeline depth and latency in cycles.

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand set presented
in_ready  output  1  block accepts operands this cycle
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_cin  input  1  carry-in for add; ignored for subtract
in_sub  input  1  0 = add, 1 = subtract
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_sum  output  WIDTH  result
out_cout  output  1  carry out of MSB (subtract: 1 = no borrow)
out_ovf  output  1  signed overflow

Behaviour:
- Arithmetic:
  - add: {cout,sum} = a + b + cin.
  - sub: {cout,sum} = a + ~b + 1; in_cin is ignored.
  - ovf = (a_msb == b_eff_msb) && (sum_msb != a_msb), where b_eff = b or ~b.
- Acceptance: a transfer occurs on a rising edge with in_valid && in_ready. Output handoff occurs with out_valid && out_ready.
- Pipeline advance: adv = !out_valid || out_ready. in_ready = adv, combinational.
  - All stages shift together when adv = 1 and hold when adv = 0.
  - Bubbles (invalid entries) propagate as bubbles. No stage-level bubble collapsing.
- Stage k (0..STAGES-1):
  - Ripples chunk k of a, b_eff plus the carry registered from stage k-1; stage 0 uses cin_eff.
  - Registers the chunk sum, carry, and a per-stage valid bit.
  - Unprocessed higher chunks of a and b_eff are carried forward in skew registers.
  - Completed lower sum chunks are carried forward.
  - Overflow is computed in the final stage from the MSB chunk.
- Latency: operands accepted at edge t appear on out_* with out_valid = 1 after edge t+STAGES-1 (output register = final stage). The result is held stable while out_valid && !out_ready.
- Throughput: one result per cycle when out_ready is held high.
- Ordering: strictly in order; no result is dropped or duplicated under any out_ready pattern.
- Capacity: STAGES entries in flight. When the output is stalled, in_ready = 0 regardless of bubbles upstream.
- Reset:
  - All valid bits 0, out_valid = 0, out_sum = 0, out_cout = 0, out_ovf = 0.
  - in_ready = 1 in the cycle after reset deasserts.
  - Reset asserted mid-operation discards all in-flight entries; none emerge afterwards.
- Simultaneous output handoff and input accept in the same cycle: legal. The pipeline shifts, and the new entry enters stage 0.
- in_a, in_b, in_sub and in_cin are sampled only on an accept edge. Values while in_ready = 0 are don't-care.

Optional Feature:
- Macro: PIPELINED_ADDSUB_SAT_EN.
- Defined:
  - On signed overflow, out_sum saturates: positive overflow gives 0 followed by all 1s (0x7F for WIDTH 8); negative overflow gives 1 followed by all 0s (0x80).
  - out_ovf still reports 1; out_cout is unchanged.
  - Saturation is applied in the final stage; latency is unchanged.
- Undefined: out_sum wraps modulo 2^WIDTH. No saturation logic is present.

Test Plan (WIDTH=8, CHUNK=4, STAGES=2):
- add 0x0F+0x01, cin=0, out_ready=1 -> out_valid on the 2nd edge after accept; sum=0x10, cout=0, ovf=0 (carry crosses the chunk boundary).
- add 0xFF+0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then add 0x7F+0x00, cin=1 -> sum=0x80, cout=0, ovf=1 (with SAT_EN: sum=0x7F, ovf=1).
- sub 0x05-0x07, in_cin=1 -> sum=0xFE, cout=0, ovf=0. Then sub 0x80-0x01 -> sum=0x7F, cout=1, ovf=1 (with SAT_EN: sum=0x80).
- out_ready=0, drive 3 back-to-back valid inputs (0x01+0x01, 0x02+0x02, 0x03+0x03) -> first two accepted, in_ready=0 for the third, out_sum=0x02 held stable. Raise out_ready -> results 0x02, 0x04, 0x06 in order, one per cycle.
- Random out_ready toggling (~50%) with 200 random add/sub transactions -> every result matches the reference model, in order, no loss or duplication.
- Assert reset for 1 cycle while 2 entries are in flight -> out_valid=0 and outputs 0 on the next cycle; no stale result appears afterwards; in_ready=1.
